// File: rtl/im_burst_mem.sv
// im_burst_mem: word-addressed instruction memory with a valid/ready request
// port, byte-strobed single-beat writes and wrapping incrementing read bursts.
// Read data passes through an RD_LAT-deep pipeline that stalls as a whole
// whenever the consumer is not accepting the current output beat.
module im_burst_mem #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 10,
    parameter int BURST_MAX = 8,
    parameter int RD_LAT    = 1,
    localparam int LEN_W    = $clog2(BURST_MAX),
    localparam int STRB_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [LEN_W-1:0]  req_len,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    input  logic              rd_ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0]  CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_stateNext;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [ADDR_W-1:0] r_burstAddr;
    logic [LEN_W-1:0]  r_burstCnt;

    logic              r_s1Valid;
    logic              r_s1Last;
    logic [DATA_W-1:0] r_s1Data;

    logic              w_adv;
    logic              w_accept;
    logic              w_issue;
    logic              w_lastIssue;

    // The pipeline only moves when the output slot is empty or being consumed;
    // new requests are taken only from IDLE and never during reset.
    assign w_adv       = !rd_valid || rd_ready;
    assign req_ready   = rst_n && (r_state == S_IDLE) && w_adv;
    assign w_accept    = req_valid && req_ready;
    assign w_issue     = (r_state == S_BURST) && w_adv;
    assign w_lastIssue = w_issue && (r_burstCnt == '0);

    // State register; reset always abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state: a read request opens a burst, the final issued beat closes it.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !req_write) begin
                    w_stateNext = S_BURST;
                end
            end
            S_BURST: begin
                if (w_lastIssue) begin
                    w_stateNext = S_IDLE;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Storage array has no reset so contents survive rst_n; writes only land in IDLE.
    always_ff @(posedge clk) begin
        if (w_accept && req_write) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (req_wstrb[i]) begin
                    r_mem[req_addr][i*8 +: 8] <= req_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Burst address and remaining-beat counter; the address wraps naturally at the top.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_burstAddr <= '0;
            r_burstCnt  <= '0;
        end else if (w_accept && !req_write) begin
            r_burstAddr <= req_addr;
            r_burstCnt  <= req_len;
        end else if (w_issue) begin
            r_burstAddr <= r_burstAddr + ADDR_ONE;
            r_burstCnt  <= r_burstCnt - CNT_ONE;
        end
    end

    // First pipeline stage captures the memory word at issue time, so later
    // writes cannot disturb beats already in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1Valid <= 1'b0;
            r_s1Last  <= 1'b0;
            r_s1Data  <= '0;
        end else if (w_adv) begin
            r_s1Valid <= w_issue;
            r_s1Last  <= w_lastIssue;
            if (w_issue) begin
                r_s1Data <= r_mem[r_burstAddr];
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic              r_s2Valid;
            logic              r_s2Last;
            logic [DATA_W-1:0] r_s2Data;

            // Second stage adds one cycle of latency and shares the global stall.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_s2Valid <= 1'b0;
                    r_s2Last  <= 1'b0;
                    r_s2Data  <= '0;
                end else if (w_adv) begin
                    r_s2Valid <= r_s1Valid;
                    r_s2Last  <= r_s1Last;
                    if (r_s1Valid) begin
                        r_s2Data <= r_s1Data;
                    end
                end
            end

            assign rd_valid = r_s2Valid;
            assign rd_last  = r_s2Last;
            assign rd_data  = r_s2Data;
        end else begin : g_lat1
            assign rd_valid = r_s1Valid;
            assign rd_last  = r_s1Last;
            assign rd_data  = r_s1Data;
        end
    endgenerate

endmodule

// File: tb/tb_im_burst_mem.sv
// tb_im_burst_mem: directed and randomized checks of im_burst_mem against a
// word-array reference memory and a queue of expected read beats.
`timescale 1ns/1ps
module tb_im_burst_mem;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 10;
    localparam int BURST_MAX = 8;
    localparam int RD_LAT    = 2;
    localparam int LEN_W     = $clog2(BURST_MAX);
    localparam int STRB_W    = DATA_W / 8;
    localparam int DEPTH     = 2 ** ADDR_W;

    logic              clk;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [LEN_W-1:0]  req_len;
    logic [DATA_W-1:0] req_wdata;
    logic [STRB_W-1:0] req_wstrb;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              rd_ready;

    int compCount = 0;
    int errCount  = 0;
    int cycleCnt  = 0;
    int stallFrom = -100;
    int rxCount   = 0;
    int acceptCycle   = 0;
    int lastBeatCycle = 0;
    bit randStall   = 1'b0;
    bit holdPending = 1'b0;
    bit accepted    = 1'b0;
    logic [DATA_W-1:0] heldData;
    logic [DATA_W:0]   lastBeat;
    logic [DATA_W-1:0] refMem [DEPTH];
    logic [DATA_W:0]   expQ [$];

    im_burst_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .BURST_MAX (BURST_MAX),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_len   (req_len),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .rd_ready  (rd_ready)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compCount++;
        if (actual !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, actual, expected, cycleCnt);
        end
    endtask

    // Reference behaviour of an accepted request: writes merge bytes into the
    // model, reads enqueue every beat with its wrapped address and last flag.
    task automatic modelAccept();
        if (req_write) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (req_wstrb[i]) refMem[req_addr][i*8 +: 8] = req_wdata[i*8 +: 8];
            end
        end else begin
            for (int b = 0; b <= int'(req_len); b++) begin
                expQ.push_back({(b == int'(req_len)), refMem[(int'(req_addr) + b) % DEPTH]});
            end
        end
    endtask

    // One clock: observe everything at the falling edge, then drive rd_ready
    // just after the rising edge for the following cycle.
    task automatic stepCycle();
        logic [DATA_W:0] expBeat;
        @(negedge clk);
        cycleCnt++;
        accepted = 1'b0;
        if (rst_n) begin
            if (rd_valid) begin
                if (holdPending) checkOutput("rd_data held under stall", 64'(rd_data), 64'(heldData));
                if (!rd_ready) begin
                    checkOutput("req_ready under stall", 64'(req_ready), 64'd0);
                end else begin
                    checkOutput("beat expected", 64'(expQ.size() != 0), 64'd1);
                    if (expQ.size() != 0) begin
                        expBeat  = expQ.pop_front();
                        lastBeat = {rd_last, rd_data};
                        checkOutput("beat last/data", 64'(lastBeat), 64'(expBeat));
                        rxCount++;
                        lastBeatCycle = cycleCnt;
                    end
                end
            end
            holdPending = rd_valid && !rd_ready;
            heldData    = rd_data;
            if (req_valid && req_ready) begin
                accepted    = 1'b1;
                acceptCycle = cycleCnt;
                modelAccept();
            end
        end
        @(posedge clk);
        #1;
        if ((cycleCnt + 1) >= stallFrom && (cycleCnt + 1) < stallFrom + 3) rd_ready = 1'b0;
        else if (randStall) rd_ready = ($urandom_range(0, 3) != 0);
        else rd_ready = 1'b1;
    endtask

    // Present one request and hold it until the DUT takes it.
    task automatic applyStimulus(input bit wr, input int addr, input int len,
                                 input logic [DATA_W-1:0] wdata, input logic [STRB_W-1:0] strb);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = ADDR_W'(addr);
        req_len   = LEN_W'(len);
        req_wdata = wdata;
        req_wstrb = strb;
        for (int t = 0; t < 100; t++) begin
            stepCycle();
            if (accepted) break;
        end
        checkOutput("request accepted", 64'(accepted), 64'd1);
        req_valid = 1'b0;
    endtask

    // Run until every expected beat has arrived, then a few idle cycles to
    // catch any extra beats.
    task automatic drainBeats();
        for (int t = 0; t < 300; t++) begin
            if (expQ.size() == 0) break;
            stepCycle();
        end
        checkOutput("drain queue empty", 64'(expQ.size()), 64'd0);
        repeat (RD_LAT + 3) stepCycle();
    endtask

    task automatic waitBeats(input int target);
        for (int t = 0; t < 60; t++) begin
            if (rxCount >= target) break;
            stepCycle();
        end
        checkOutput("beats reached", 64'(rxCount), 64'(target));
    endtask

    // Asynchronous reset asserted in the middle of a clock phase.
    task automatic resetMidCycle();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("reset rd_data", 64'(rd_data), 64'd0);
        checkOutput("reset rd_last", 64'(rd_last), 64'd0);
        checkOutput("reset req_ready", 64'(req_ready), 64'd0);
        expQ.delete();
        holdPending = 1'b0;
        repeat (2) stepCycle();
        rst_n = 1'b1;
        #1;
        checkOutput("release req_ready", 64'(req_ready), 64'd1);
        checkOutput("release rd_valid", 64'(rd_valid), 64'd0);
    endtask

    initial begin
        int base;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_wdata = '0;
        req_wstrb = '0;
        rd_ready  = 1'b1;

        #7;
        checkOutput("power-up rd_valid", 64'(rd_valid), 64'd0);
        checkOutput("power-up rd_data", 64'(rd_data), 64'd0);
        checkOutput("power-up req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        checkOutput("idle req_ready", 64'(req_ready), 64'd1);

        $display("[TB] preload memory");
        for (int a = 0; a < DEPTH; a++) applyStimulus(1'b1, a, 0, $urandom, 4'hF);

        $display("[TB] byte strobe write and latency");
        applyStimulus(1'b1, 5, 0, 32'hDEADBEEF, 4'hF);
        applyStimulus(1'b1, 5, 3, 32'h00000011, 4'h1);
        applyStimulus(1'b0, 5, 0, 32'h0, 4'h0);
        base = acceptCycle;
        drainBeats();
        checkOutput("strobed word", 64'(lastBeat), 64'({1'b1, 32'hDEADBE11}));
        checkOutput("read latency", 64'(lastBeatCycle - base), 64'(RD_LAT + 1));
        applyStimulus(1'b1, 5, 0, 32'hFFFFFFFF, 4'h0);
        applyStimulus(1'b0, 5, 0, 32'h0, 4'h0);
        drainBeats();
        checkOutput("zero strobe no-op", 64'(lastBeat), 64'({1'b1, 32'hDEADBE11}));

        $display("[TB] wrap burst");
        applyStimulus(1'b1, 1022, 0, 32'hA, 4'hF);
        applyStimulus(1'b1, 1023, 0, 32'hB, 4'hF);
        applyStimulus(1'b1, 0,    0, 32'hC, 4'hF);
        applyStimulus(1'b1, 1,    0, 32'hD, 4'hF);
        base = rxCount;
        applyStimulus(1'b0, 1022, 3, 32'h0, 4'h0);
        drainBeats();
        checkOutput("wrap beat count", 64'(rxCount - base), 64'd4);
        checkOutput("wrap final beat", 64'(lastBeat), 64'({1'b1, 32'hD}));

        $display("[TB] backpressure");
        base = rxCount;
        applyStimulus(1'b0, 200, 7, 32'h0, 4'h0);
        waitBeats(base + 1);
        stallFrom = cycleCnt + 1;
        drainBeats();
        checkOutput("stalled burst beats", 64'(rxCount - base), 64'd8);

        $display("[TB] back-to-back bursts");
        base = rxCount;
        applyStimulus(1'b0, 300, 1, 32'h0, 4'h0);
        applyStimulus(1'b0, 400, 1, 32'h0, 4'h0);
        drainBeats();
        checkOutput("back-to-back beats", 64'(rxCount - base), 64'd4);

        $display("[TB] reset mid-burst");
        base = rxCount;
        applyStimulus(1'b0, 100, 7, 32'h0, 4'h0);
        waitBeats(base + 2);
        resetMidCycle();
        repeat (RD_LAT + 4) stepCycle();
        checkOutput("aborted burst beats", 64'(rxCount - base), 64'd2);
        applyStimulus(1'b0, 100, 7, 32'h0, 4'h0);
        drainBeats();
        checkOutput("reread after reset", 64'(rxCount - base), 64'd10);

        $display("[TB] randomized traffic");
        randStall = 1'b1;
        for (int n = 0; n < 250; n++) begin
            if ($urandom_range(0, 2) == 0)
                applyStimulus(1'b1, $urandom_range(0, DEPTH - 1), 0, $urandom, STRB_W'($urandom_range(0, 15)));
            else
                applyStimulus(1'b0, $urandom_range(0, DEPTH - 1), $urandom_range(0, BURST_MAX - 1), 32'h0, 4'h0);
            if ($urandom_range(0, 3) == 0) stepCycle();
        end
        randStall = 1'b0;
        drainBeats();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCount, errCount);
        $finish;
    end

endmodule
